command_tx: RTL
===============

// Module: command_tx
// PURPOSE
//  Downstream consumer of the periodic command issuer. Accepts a 2-bit
//  command with a start strobe, wraps it in a framed byte and shifts it out
//  LSB-first on a single asynchronous serial line (UART style).
//  Drives ready_command back to the issuer, so the issuer can pace its commands.
//  Sits between the control FSM and the physical TX pin of the link.
// PARAMETERS
//  CLKS_PER_BIT  217   clk cycles per serial bit (25 MHz / 115200 baud); legal range >= 2
//  HDR_NIBBLE    4'hA  constant upper nibble of every payload byte
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  asynchronous, active-low reset (0 = reset)
//  command_1      in   2  command code, sampled on accepted start
//  start          in   1  level request; a frame is launched on any edge where start=1 and ready_command=1
//  ready_command  out  1  1 = idle, can accept a command
//  tx             out  1  serial line output; idle level 1
//  done           out  1  one-cycle pulse when the stop bit completes
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, tx=1, ready_command=1, done=0, bit counter=0, baud counter=0.
//    Reset mid-frame aborts the frame immediately, and tx returns to 1 with no glitch to 0.
//  - All outputs are registered.
//  - Payload byte D = {HDR_NIBBLE, 2'b00, command_1}, latched at the accept edge.
//    Later changes on command_1 do not affect the frame in flight.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE:   tx=1, ready_command=1. On start=1: latch D, tx<=0, ready_command<=0, go to START.
//    START:  tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//    DATA:   tx=D[i] for CLKS_PER_BIT cycles each, i=0..7.
//            After i=7, go to PARITY (if enabled) or STOP.
//    PARITY: tx=^D (even parity) for CLKS_PER_BIT cycles, then go to STOP.
//    STOP:   tx=1 for CLKS_PER_BIT cycles. On the last cycle: go to IDLE, ready_command<=1, done<=1.
//  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit change.
//    Its width is $clog2(CLKS_PER_BIT).
//  - Frame length: NB*CLKS_PER_BIT cycles from the accept edge until ready_command rises.
//    NB = 10 without parity, 11 with parity.
//  - start while ready_command=0 is ignored; it is neither queued nor counted.
//  - start held high permanently: a new frame is accepted on the first IDLE edge.
//    Minimum frame-to-frame spacing is NB*CLKS_PER_BIT+1 cycles; there is exactly 1 idle cycle with tx=1.
//  - done and ready_command rise on the same edge. done clears on the next edge.
//  - The illegal/default state recovers to IDLE with tx=1.
// CONFIGURATION
//  CMD_TX_PARITY_EN
//    defined:   an even-parity bit is inserted between D[7] and the stop bit; NB=11.
//    undefined: no parity state exists; NB=10.
//    Port list is identical in both builds.
// TESTING
//  Run benches with CLKS_PER_BIT=4 unless stated otherwise.
//  1 Reset: hold rst=0 for 3 cycles -> tx=1, ready_command=1, done=0.
//    Release rst -> outputs unchanged while start=0.
//  2 Single frame, no parity: command_1=2'b10, one-cycle start.
//    -> D=0xA2; tx sequence per 4 cycles: 0 | 0,1,0,0,0,1,0,1 | 1.
//    -> ready_command low for exactly 40 cycles; done pulses once at cycle 40.
//  3 Parity build (CMD_TX_PARITY_EN): command_1=2'b10.
//    -> parity bit=1 after D[7]; ready_command low for exactly 44 cycles.
//  4 Busy ignore: second start with command_1=2'b01 at cycle 10 of a frame.
//    -> frame content unchanged; no second frame; only one done.
//  5 Back-to-back: start held 1, command_1 incrementing 0,1,2,3.
//    -> four frames with D=0xA0,0xA1,0xA2,0xA3; 1-cycle idle gap between frames; 4 done pulses.
//  6 Reset mid-frame: assert rst=0 during DATA bit 3.
//    -> tx=1 and ready_command=1 asynchronously.
//    -> release rst, then start -> complete, correct frame.

Source files
------------

// File: rtl/command_tx.sv
// UART-style framed transmitter for 2-bit commands: start, 8 data bits LSB-first, optional parity, stop.
// Optional even-parity bit enabled by defining CMD_TX_PARITY_EN.
module command_tx #(
   parameter int          CLKS_PER_BIT = 217,
   parameter logic [3:0]  HDR_NIBBLE   = 4'hA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] command_1,
   input  logic       start,
   output logic       ready_command,
   output logic       tx,
   output logic       done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef CMD_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]    state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    data;
   logic          bit_end;

   assign bit_end = (baud == BAUD_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         tx            <= 1'b1;
         ready_command <= 1'b1;
         done          <= 1'b0;
         bit_idx       <= '0;
         baud          <= '0;
         data          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx            <= 1'b1;
               ready_command <= 1'b1;
               baud          <= '0;
               bit_idx       <= '0;
               if (start) begin
                  data          <= {HDR_NIBBLE, 2'b00, command_1};
                  tx            <= 1'b0;
                  ready_command <= 1'b0;
                  state         <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= data[0];
                  state   <= S_DATA;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef CMD_TX_PARITY_EN
                     tx    <= ^data;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     // tx is registered, so the next bit is loaded on the boundary edge
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= data[bit_idx + 3'd1];
                  end
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
`ifdef CMD_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  baud  <= '0;
                  tx    <= 1'b1;
                  state <= S_STOP;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  baud          <= '0;
                  ready_command <= 1'b1;
                  done          <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            default: begin
               tx            <= 1'b1;
               ready_command <= 1'b1;
               baud          <= '0;
               bit_idx       <= '0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule
